// File: rtl/csr_exec.sv
// CSR instruction sequencer. It takes one Zicsr instruction from the core,
// reads the addressed CSR, optionally writes the modified value back, and
// then returns the old value (or an illegal flag) to the core.
module csr_exec #(
  parameter int unsigned REG_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  // Request channel from decode/execute
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [11:0]      req_addr,
  input  logic [4:0]       req_rs1_idx,
  input  logic [REG_W-1:0] req_rs1_val,
  // Response channel back to the core
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [REG_W-1:0] resp_rdata,
  output logic             resp_illegal,
  // CSR register file port
  output logic [11:0]      csr_addr,
  output logic             csr_wen,
  output logic [REG_W-1:0] csr_wdata,
  input  logic [REG_W-1:0] csr_rdata
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2,
    StResp  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [2:0]       funct3_q;
  logic [11:0]      addr_q;
  logic [4:0]       rs1_idx_q;
  logic [REG_W-1:0] rs1_val_q;
  logic [REG_W-1:0] old_q;
  logic             illegal_q;

  logic             accept;
  logic [REG_W-1:0] opnd;
  logic             wr_req;
  logic             illegal;
  logic [REG_W-1:0] wdata;

  assign accept = req_valid && req_ready;

  // Decode of the latched instruction: operand, write need, legality, new value
  always_comb begin
    opnd    = funct3_q[2] ? {{(REG_W-5){1'b0}}, rs1_idx_q} : rs1_val_q;
    // RW/RWI always write; set/clear forms write only with a nonzero source
    wr_req  = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != 5'd0);
    // funct3 000/100 are not CSR ops; writes to 0xC00-0xFFF are read-only
    illegal = (funct3_q[1:0] == 2'b00) || (wr_req && (addr_q[11:10] == 2'b11));
    wdata   = '0;
    unique case (funct3_q[1:0])
      2'b01:   wdata = opnd;
      2'b10:   wdata = old_q | opnd;
      2'b11:   wdata = old_q & ~opnd;
      default: wdata = '0;
    endcase
  end

  // State register and instruction/result capture
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StIdle;
      funct3_q  <= '0;
      addr_q    <= '0;
      rs1_idx_q <= '0;
      rs1_val_q <= '0;
      old_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        funct3_q  <= req_funct3;
        addr_q    <= req_addr;
        rs1_idx_q <= req_rs1_idx;
        rs1_val_q <= req_rs1_val;
      end
      if (state_q == StRead) begin
        old_q     <= csr_rdata;
        illegal_q <= illegal;
      end
    end
  end

  // Next-state logic and Moore outputs
  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_illegal = 1'b0;
    csr_addr     = '0;
    csr_wen      = 1'b0;
    csr_wdata    = '0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = StRead;
        end
      end
      StRead: begin
        csr_addr = addr_q;
        // Illegal ops still read: CSR reads have no side effects
        state_d  = (illegal || !wr_req) ? StResp : StWrite;
      end
      StWrite: begin
        csr_addr  = addr_q;
        csr_wen   = 1'b1;
        csr_wdata = wdata;
        state_d   = StResp;
      end
      StResp: begin
        resp_valid   = 1'b1;
        resp_illegal = illegal_q;
        resp_rdata   = illegal_q ? '0 : old_q;
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
